// File: rtl/serializer_pkg.sv
// Shared types and constants for the 10:2 DDR TMDS serializer.
// Slot 0 of each word carries bits [1:0]; the counter idles on LAST_SLOT so a load is always pending.
package serializer_pkg;

   localparam int WORD_W = 10;
   localparam int SLOTS  = WORD_W / 2;
   localparam int CNT_W  = $clog2(SLOTS);
   localparam int LANES  = 2;
   localparam int LANE_DATA = 0;
   localparam int LANE_CLK  = 1;

   typedef logic [WORD_W-1:0] tmds_word_t;
   typedef logic [CNT_W-1:0]  slot_t;

   localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

   // Low half ones, high half zeros: the clock lane is high for the first half of each pixel period.
   function automatic tmds_word_t make_clk_pattern();
      tmds_word_t pat;
      pat = '0;
      for (int i = 0; i < SLOTS; i++) begin
         pat[i] = 1'b1;
      end
      return pat;
   endfunction

   localparam tmds_word_t CLK_PATTERN = make_clk_pattern();

   // Any counter value at or past the last slot forces a load, so a corrupted count self-heals.
   function automatic logic is_load_slot(input slot_t cnt);
      return (cnt >= LAST_SLOT);
   endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serializer lane: parallel load, then two bits per cycle shifted out LSB first.
// The output pair is taken straight from the low register bits so it is glitch-free.
module serializer_lane
   import serializer_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [1:0]   pair
);

   logic [W-1:0] sr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_reg <= '0;
      end else if (load) begin
         sr_reg <= load_value;
      end else begin
         sr_reg <= {2'b00, sr_reg[W-1:2]};
      end
   end

   assign pair = sr_reg[1:0];

endmodule

// File: rtl/serializer.sv
// 10:2 DDR serializer on the 5x shift clock, with a phase-matched TMDS clock lane.
// Optional: define SERIALIZER_LOAD_STROBE_EN to add the o_load word-start strobe.
module serializer
   import serializer_pkg::*;
(
   input  logic              i_clk_shift,
   input  logic              i_rst,
   input  logic [WORD_W-1:0] i_data,
   output logic [1:0]        o_data,
   output logic [1:0]        o_clk
`ifdef SERIALIZER_LOAD_STROBE_EN
   ,
   output logic              o_load
`endif
);

   slot_t      cnt_reg;
   logic       load;
   tmds_word_t lane_value [LANES];
   logic [1:0] lane_pair  [LANES];

   assign load = is_load_slot(cnt_reg);

   // Reset parks the counter on the last slot so the first edge after release loads a word.
   always_ff @(posedge i_clk_shift or posedge i_rst) begin
      if (i_rst) begin
         cnt_reg <= LAST_SLOT;
      end else if (load) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + slot_t'(1);
      end
   end

   assign lane_value[LANE_DATA] = i_data;
   assign lane_value[LANE_CLK]  = CLK_PATTERN;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         serializer_lane #(
            .W (WORD_W)
         ) u_lane (
            .clk        (i_clk_shift),
            .rst        (i_rst),
            .load       (load),
            .load_value (lane_value[gi]),
            .pair       (lane_pair[gi])
         );
      end
   endgenerate

   assign o_data = lane_pair[LANE_DATA];
   assign o_clk  = lane_pair[LANE_CLK];

`ifdef SERIALIZER_LOAD_STROBE_EN
   logic load_strobe_reg;

   // High in the slot right after a load edge, which is exactly the cnt == 0 slot.
   always_ff @(posedge i_clk_shift or posedge i_rst) begin
      if (i_rst) begin
         load_strobe_reg <= 1'b0;
      end else begin
         load_strobe_reg <= load;
      end
   end

   assign o_load = load_strobe_reg;
`endif

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: stimulus pushes hand-computed slot values, a monitor pops at each falling edge.
// Works with or without SERIALIZER_LOAD_STROBE_EN; o_load is only checked when the port exists.
module tb_serializer;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [9:0] i_data = '0;
   logic [1:0] o_data;
   logic [1:0] o_clk;
   logic       o_load_s;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] d;
      logic [1:0] c;
      logic       l;
      string      nm;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

`ifdef SERIALIZER_LOAD_STROBE_EN
   logic o_load;
   assign o_load_s = o_load;
   serializer dut (
      .i_clk_shift (clk),
      .i_rst       (i_rst),
      .i_data      (i_data),
      .o_data      (o_data),
      .o_clk       (o_clk),
      .o_load      (o_load)
   );
`else
   assign o_load_s = 1'b0;
   serializer dut (
      .i_clk_shift (clk),
      .i_rst       (i_rst),
      .i_data      (i_data),
      .o_data      (o_data),
      .o_clk       (o_clk)
   );
`endif

   // Monitor: one comparison per expected entry, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            checks++;
            bad = (o_data !== e.d) || (o_clk !== e.c);
`ifdef SERIALIZER_LOAD_STROBE_EN
            bad = bad || (o_load_s !== e.l);
`endif
            if (bad) begin
               errors++;
               $display("FAIL %s t=%0t: got data=%b clk=%b load=%b, want data=%b clk=%b load=%b",
                        e.nm, $time, o_data, o_clk, o_load_s, e.d, e.c, e.l);
            end else begin
               $display("ok   %s t=%0t: data=%b clk=%b load=%b", e.nm, $time, o_data, o_clk, o_load_s);
            end
         end
      end
   end

   task automatic push(input logic [1:0] d, input logic [1:0] c, input logic l, input string nm);
      exp_t e;
      e.d = d;
      e.c = c;
      e.l = l;
      e.nm = nm;
      exp_q.push_back(e);
   endtask

   // Drive inputs for the next rising edge, then queue the output expected after it.
   task automatic cyc(input logic rst, input logic [9:0] d,
                      input logic [1:0] ed, input logic [1:0] ec, input logic el, input string nm);
      i_rst = rst;
      i_data = d;
      @(posedge clk);
      #1;
      push(ed, ec, el, nm);
      @(negedge clk);
      #2;
   endtask

   // One full word: d_first is present at the load edge, d_rest during the remaining slots.
   task automatic word(input logic [9:0] d_first, input logic [9:0] d_rest,
                       input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2,
                       input logic [1:0] e3, input logic [1:0] e4, input string nm);
      logic [1:0] ed [5];
      logic [1:0] ec [5];
      ed[0] = e0; ed[1] = e1; ed[2] = e2; ed[3] = e3; ed[4] = e4;
      ec[0] = 2'b11; ec[1] = 2'b11; ec[2] = 2'b01; ec[3] = 2'b00; ec[4] = 2'b00;
      for (int s = 0; s < 5; s++) begin
         cyc(1'b0, (s == 0) ? d_first : d_rest, ed[s], ec[s], (s == 0), nm);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 10'h000, 2'b00, 2'b00, 1'b0, "reset");
      end

      for (int w = 0; w < 3; w++) begin
         word(10'b0000000001, 10'b0000000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "lsb_word");
      end

      for (int w = 0; w < 2; w++) begin
         word(10'b1111000011, 10'b1111000011, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, "pattern");
      end

      word(10'h3FF, 10'h000, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, "midword_hold");
      word(10'h000, 10'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "next_boundary");

      // Reset pulse landing in slot 2 of a word.
      cyc(1'b0, 10'h155, 2'b01, 2'b11, 1'b1, "pre_rst");
      cyc(1'b0, 10'h000, 2'b01, 2'b11, 1'b0, "pre_rst");
      i_rst = 1'b0;
      @(posedge clk);
      #1;
      i_rst = 1'b1;
      push(2'b00, 2'b00, 1'b0, "async_rst");
      @(negedge clk);
      #2;
      cyc(1'b1, 10'h155, 2'b00, 2'b00, 1'b0, "in_rst");
      cyc(1'b1, 10'h155, 2'b00, 2'b00, 1'b0, "in_rst");

      word(10'h155, 10'h155, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, "restart");
      word(10'b1000000010, 10'b1000000010, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, "edge_bits");

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
